// File: rtl/ifu_inst_queue.sv
// rtl/ifu_inst_queue.sv - fetch-to-decode instruction queue; optional same-cycle bypass when IFU_IQ_BYPASS_EN is defined
module ifu_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                      (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign in_ready = !full;
    assign count    = wr_ptr - rd_ptr;

    // A pop only ever retires a stored entry; a bypassed entry never touches storage.
    assign pop = !empty && out_ready;

`ifdef IFU_IQ_BYPASS_EN
    logic bypass;
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign out_pc    = bypass ? in_pc   : pc_mem[rd_ptr[IDX_W-1:0]];
    assign out_inst  = bypass ? in_inst : inst_mem[rd_ptr[IDX_W-1:0]];
    assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
    assign out_valid = !empty;
    assign out_pc    = pc_mem[rd_ptr[IDX_W-1:0]];
    assign out_inst  = inst_mem[rd_ptr[IDX_W-1:0]];
    assign push      = in_valid && in_ready;
`endif

    // Storage is intentionally left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr[IDX_W-1:0]]   <= in_pc;
            inst_mem[wr_ptr[IDX_W-1:0]] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// tb/tb_ifu_inst_queue.sv - directed self-checking bench for ifu_inst_queue
module tb_ifu_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    ifu_inst_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    task automatic test_order();
        push_one(64'h8000_0000, 32'h0000_0413);
        push_one(64'h8000_0004, 32'h0010_0073);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL order_count got=%0d exp=2", count); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL order_valid got=%0b exp=1", out_valid); end
        out_ready = 1'b1;
        total++; if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL order_pc0 got=%h exp=80000000", out_pc); end
        total++; if (out_inst !== 32'h0000_0413) begin bad++; $display("FAIL order_inst0 got=%h exp=00000413", out_inst); end
        step();
        total++; if (out_pc !== 64'h8000_0004) begin bad++; $display("FAIL order_pc1 got=%h exp=80000004", out_pc); end
        total++; if (out_inst !== 32'h0010_0073) begin bad++; $display("FAIL order_inst1 got=%h exp=00100073", out_inst); end
        step();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL order_drain_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_drain_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push_one(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        in_valid = 1'b1; in_pc = 64'h8000_0010; in_inst = 32'h104;
        step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        total++; if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL full_pop_pc got=%h exp=80000000", out_pc); end
        step();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%0b exp=1", in_ready); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_after_pop got=%0d exp=3", count); end
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_fifth_accepted got=%0d exp=4", count); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 + 64'(4 * i)) begin
                bad++; $display("FAIL full_drain_%0d got=%0b/%h exp=1/%h", i, out_valid, out_pc, 64'h8000_0000 + 64'(4 * i));
            end
            step();
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        push_one(64'h8000_0000, 32'h200);
        push_one(64'h8000_0004, 32'h201);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 2; k < 10; k++) begin
            in_pc   = 64'h8000_0000 + 64'(4 * k);
            in_inst = 32'h200 + 32'(k);
            total++;
            if (out_pc !== 64'h8000_0000 + 64'(4 * (k - 2)) || count !== 3'd2) begin
                bad++; $display("FAIL b2b_%0d got=%h/%0d exp=%h/2", k, out_pc, count, 64'h8000_0000 + 64'(4 * (k - 2)));
            end
            step();
        end
        in_valid = 1'b0;
        for (int k = 8; k < 10; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 + 64'(4 * k)) begin
                bad++; $display("FAIL b2b_tail_%0d got=%0b/%h exp=1/%h", k, out_valid, out_pc, 64'h8000_0000 + 64'(4 * k));
            end
            step();
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_one(64'h8000_0100 + 64'(4 * i), 32'h300 + 32'(i));
        flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_1000; in_inst = 32'h3ff; out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        push_one(64'h8000_2000, 32'h400);
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_2000) begin bad++; $display("FAIL flush_next got=%0b/%h exp=1/80002000", out_valid, out_pc); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_inst = 32'h0000_0413; out_ready = 1'b1;
`ifdef IFU_IQ_BYPASS_EN
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin bad++; $display("FAIL bypass_same got=%0b/%h exp=1/80000000", out_valid, out_pc); end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL bypass_after got=%0d/%0b exp=0/0", count, out_valid); end
`else
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_same got=%0b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin bad++; $display("FAIL nobypass_next got=%0b/%h exp=1/80000000", out_valid, out_pc); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL nobypass_count got=%0d exp=1", count); end
        step();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL nobypass_drain got=%0d exp=0", count); end
`endif
    endtask

    task automatic test_reset_mid();
        push_one(64'h8000_3000, 32'h500);
        push_one(64'h8000_3004, 32'h501);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid got=%0d/%0b exp=0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_inst_queue.md
Name: ifu_inst_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Captures each fetched {pc, inst} pair on a valid/ready handshake and holds up to DEPTH entries in order.
- Presents the oldest entry to decode.
- Decouples fetch latency (icache misses) from decode stalls; discards all buffered entries on redirect (branch, exception, exception return).

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
PC_W, 64, program counter width
INST_W, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  fetch stage offers an entry this cycle
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  PC_W  pc of offered instruction
in_inst  input  INST_W  offered instruction word
flush  input  1  redirect; discard all buffered entries
out_valid  output  1  head entry is valid
out_ready  input  1  decode consumes head entry this cycle
out_pc  output  PC_W  pc of head entry
out_inst  output  INST_W  instruction of head entry
count  output  $clog2(DEPTH)+1  number of buffered entries

Behaviour:
- Storage: circular array of DEPTH {pc, inst} entries. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- Empty: pointers equal. Full: index bits equal and wrap bits differ.
- count = wr_ptr - rd_ptr (modular). Range 0..DEPTH.
- Push: in_valid & in_ready. Writes the entry at wr_ptr; wr_ptr increments on the next edge.
- Pop: out_valid & out_ready. rd_ptr increments on the next edge.
- Ready/valid logic:
  - in_ready = !full; it depends only on registered state, with no combinational path from out_ready.
  - out_valid = !empty (baseline build).
  - out_pc/out_inst = entry at rd_ptr, driven combinationally from storage. Their value is don't-care when out_valid=0.
- Simultaneous push and pop:
  - Non-empty and not full: both occur; count unchanged.
  - Full: in_ready=0, so only the pop occurs; the slot reopens next cycle.
- Wrap-around: pointers wrap modulo 2*DEPTH. Ordering is preserved across the wrap.
- Flush:
  - Next edge sets wr_ptr=rd_ptr=0, so the queue is empty the following cycle.
  - A push or pop in the flush cycle is discarded; the flush cycle's in_pc is not retained.
  - in_ready stays per full state during the flush cycle.
  - flush has priority over push/pop.
- Reset (rst=1 at an edge): pointers=0. Resulting outputs: out_valid=0, in_ready=1, count=0. Storage contents are not reset.
  - Reset mid-operation discards all entries exactly as flush does.
- Latency: minimum 1 cycle from push to out_valid (baseline build).
- Handshake rules: the producer must hold in_pc/in_inst stable while in_valid=1 and in_ready=0. out_* are stable while out_valid=1 and out_ready=0, unless flush.

Optional Feature:
- Macro: IFU_IQ_BYPASS_EN.
- Defined: when the queue is empty and in_valid=1 and flush=0:
  - out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally (0-cycle latency).
  - If out_ready=1 that cycle, the entry is consumed without being written and the pointers are unchanged.
  - Otherwise it is written normally.
  - count excludes the bypassed entry.
- Undefined: no bypass; out_valid depends only on registered state; minimum latency 1 cycle.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0.
- Push pc=0x80000000/inst=0x00000413, then pc=0x80000004/inst=0x00100073 with out_ready=0 -> count=2. Then out_ready=1 -> out_pc pops 0x80000000 then 0x80000004 in order; count returns to 0.
- Push 4 entries (pc 0x80000000..0x8000000C) with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is held and not accepted. Pop one -> in_ready=1 next cycle; 5th entry (pc 0x80000010) accepted and later emerges after 0x8000000C.
- Continuous push+pop for 10 entries (pc 0x80000000+4k) with queue holding 2 -> count stays 2 across pointer wrap; output pc sequence strictly increasing by 4, no loss or duplication.
- Queue holding 3 entries; assert flush with in_valid=1, pc=0x80001000 -> next cycle out_valid=0, count=0. Then push pc=0x80002000 -> it is the next output.
- IFU_IQ_BYPASS_EN defined, empty queue, in_valid=1 pc=0x80000000, out_ready=1 -> same cycle out_valid=1, out_pc=0x80000000; next cycle count=0. Macro undefined -> out_valid=0 that cycle; entry appears the next cycle.
